// File: rtl/tdc_word_decoder_pkg.sv
// tdc_word_decoder_pkg: shared TDC field widths and defaults, also used by the TDC merge logic.
package tdc_word_decoder_pkg;
   localparam int COUNTER_DIG_DEF = 8;
   localparam int NUM_DECODE_DEF = 6;
   localparam int DIG_OUT_DEF = COUNTER_DIG_DEF + 2*NUM_DECODE_DEF;
   localparam int BINS_PER_CLK_DEF = 40;
   localparam int FIFO_DEPTH_DEF = 8;
endpackage

// File: rtl/tdc_result_fifo.sv
// tdc_result_fifo: FWFT result buffer; a write becomes visible at the head one cycle after it lands.
module tdc_result_fifo #(
   parameter int W = 17,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     valid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic push, pop;
   assign pop = rd_en && valid;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign push = wr_en && (!full || pop);
   assign rd_data = valid ? mem[rp] : '0;
   always_ff @(posedge clk)
      if (push) mem[wp] <= wr_data;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         level <= '0;
         valid <= 1'b0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         level <= level + (AW+1)'(push) - (AW+1)'(pop);
         // a same-cycle write is not counted, so a fresh entry shows one cycle later
         valid <= (level - (AW+1)'(pop)) != '0;
      end
endmodule

// File: rtl/tdc_word_decoder.sv
// tdc_word_decoder: merged TDC word -> clamped fine-bin interval, two pipeline stages into an FWFT buffer.
module tdc_word_decoder
   import tdc_word_decoder_pkg::*;
#(
   parameter int COUNTER_DIG = COUNTER_DIG_DEF,
   parameter int NUM_DECODE = NUM_DECODE_DEF,
   parameter int BINS_PER_CLK = BINS_PER_CLK_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int DIG_OUT = COUNTER_DIG + 2*NUM_DECODE,
   localparam int RES_W = COUNTER_DIG + NUM_DECODE + 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIG_OUT-1:0]            in_word,
   input  logic                          in_valid,
   output logic [RES_W-1:0]              out_interval,
   output logic                          out_neg,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   level
);
   logic [RES_W-1:0] scaled, start1, stop1, raw, int2;
   logic [RES_W:0] head;
   logic v1, v2, neg2, full, empty, pop;
   assign raw = scaled + start1 - stop1;
   assign pop = out_valid && out_ready;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         scaled <= '0;
         start1 <= '0;
         stop1 <= '0;
         int2 <= '0;
         neg2 <= 1'b0;
         overflow <= 1'b0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            scaled <= RES_W'(in_word[DIG_OUT-1 -: COUNTER_DIG]) * RES_W'(BINS_PER_CLK);
            start1 <= RES_W'(in_word[2*NUM_DECODE-1 -: NUM_DECODE]);
            stop1 <= RES_W'(in_word[NUM_DECODE-1:0]);
         end
         v2 <= v1;
         neg2 <= raw[RES_W-1];
         int2 <= raw[RES_W-1] ? '0 : raw;
         // a drop in the same cycle as a clear keeps the flag set
         overflow <= (v2 && full && !pop) || (overflow && !clr_overflow);
      end
   tdc_result_fifo #(.W(RES_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .wr_en(v2),
      .wr_data({neg2, int2}),
      .rd_en(out_ready),
      .rd_data(head),
      .valid(out_valid),
      .full(full),
      .empty(empty),
      .level(level)
   );
   assign out_neg = head[RES_W];
   assign out_interval = head[RES_W-1:0];
endmodule

// File: tb/tb_tdc_word_decoder.sv
// tb_tdc_word_decoder: directed table, corner sequences and random traffic against a queue-based model.
module tb_tdc_word_decoder;
   localparam int DEPTH = 8;
   logic clk = 0, rst = 1;
   logic [19:0] in_word = '0;
   logic in_valid = 0, out_ready = 0, clr_overflow = 0;
   logic [15:0] out_interval;
   logic out_neg, out_valid, overflow;
   logic [3:0] level;
   int tests = 0, fails = 0, cyc = 0;
   typedef struct {int due; logic [16:0] res;} pend_t;
   pend_t pend[$];
   logic [16:0] q[$];
   bit m_valid = 0, ovf = 0;
   typedef struct {int c; int s; int p; int e_int; bit e_neg;} vec_t;
   vec_t tbl[7];
   int exp_q[$], got_q[$];
   int max_lvl;
   always #5 clk = ~clk;
   tdc_word_decoder dut (
      .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
      .out_interval(out_interval), .out_neg(out_neg), .out_valid(out_valid),
      .out_ready(out_ready), .overflow(overflow), .clr_overflow(clr_overflow), .level(level)
   );
   function automatic logic [19:0] mk(int c, int s, int p);
      logic [7:0] cc = 8'(c);
      logic [5:0] ss = 6'(s), pp = 6'(p);
      return {cc, ss, pp};
   endfunction
   // interval straight from the word fields with integer arithmetic
   function automatic logic [16:0] ref_res(logic [19:0] w);
      int raw = int'(w[19:12]) * 40 + int'(w[11:6]) - int'(w[5:0]);
      return raw < 0 ? 17'h10000 : {1'b0, 16'(raw)};
   endfunction
   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic step(bit v, logic [19:0] w, bit rdy, bit clr);
      bit pop, wr;
      int sz;
      logic [16:0] r = '0;
      in_valid = v; in_word = w; out_ready = rdy; clr_overflow = clr;
      @(posedge clk);
      pop = m_valid && rdy;
      sz = q.size();
      if (pop) void'(q.pop_front());
      wr = pend.size() > 0 && pend[0].due == cyc;
      if (wr) r = pend.pop_front().res;
      if (v) pend.push_back('{cyc + 2, ref_res(w)});
      if (clr) ovf = 0;
      if (wr) begin
         if (sz == DEPTH && !pop) ovf = 1;
         else q.push_back(r);
      end
      m_valid = (sz - int'(pop)) != 0;
      cyc++;
      #1;
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("level", int'(level), q.size());
      chk("overflow", int'(overflow), int'(ovf));
      if (m_valid) begin
         chk("out_interval", int'(out_interval), int'(q[0][15:0]));
         chk("out_neg", int'(out_neg), int'(q[0][16]));
      end
   endtask
   task automatic do_reset();
      rst = 1;
      in_valid = 0; out_ready = 0; clr_overflow = 0;
      #1;
      pend.delete(); q.delete(); m_valid = 0; ovf = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_interval", int'(out_interval), 0);
      chk("rst_neg", int'(out_neg), 0);
      @(posedge clk);
      #1;
      rst = 0;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, limit %0d ns", 2_000_000);
      $fatal(1);
   end
   initial begin
      tbl[0] = '{3, 10, 25, 105, 0};
      tbl[1] = '{0, 5, 20, 0, 1};
      tbl[2] = '{255, 63, 0, 10263, 0};
      tbl[3] = '{0, 0, 0, 0, 0};
      tbl[4] = '{1, 0, 63, 0, 1};
      tbl[5] = '{2, 0, 63, 17, 0};
      tbl[6] = '{0, 63, 0, 63, 0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(1, mk(tbl[i].c, tbl[i].s, tbl[i].p), 1, 0);
         chk("lat_n0", int'(out_valid), 0);
         step(0, '0, 1, 0);
         chk("lat_n1", int'(out_valid), 0);
         step(0, '0, 1, 0);
         chk("lat_n2", int'(out_valid), 0);
         step(0, '0, 1, 0);
         chk("lat_n3", int'(out_valid), 1);
         chk("tbl_interval", int'(out_interval), tbl[i].e_int);
         chk("tbl_neg", int'(out_neg), int'(tbl[i].e_neg));
         step(0, '0, 1, 0);
         chk("single_beat", int'(out_valid), 0);
      end
      // 9 strobes into a stalled buffer: the ninth is dropped
      for (int i = 0; i < 9; i++) step(1, mk(i, i, 0), 0, 0);
      for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
      chk("full_level", int'(level), 8);
      chk("full_overflow", int'(overflow), 1);
      for (int k = 0; k < 8; k++) begin
         chk("drain_order", int'(out_interval), k * 41);
         step(0, '0, 1, 0);
      end
      chk("drain_empty", int'(out_valid), 0);
      step(0, '0, 0, 1);
      chk("clr_overflow", int'(overflow), 0);
      // drop lands on the same edge as a clear: set wins
      for (int i = 0; i < 8; i++) step(1, mk(i + 1, 0, 0), 0, 0);
      for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
      step(1, mk(9, 9, 9), 0, 0);
      step(0, '0, 0, 0);
      step(0, '0, 0, 1);
      chk("set_wins", int'(overflow), 1);
      step(0, '0, 0, 1);
      chk("clr_after", int'(overflow), 0);
      for (int i = 0; i < 12; i++) step(0, '0, 1, 0);
      chk("drained2", int'(out_valid), 0);
      // back-to-back stream with a free-running consumer
      got_q.delete(); exp_q.delete(); max_lvl = 0;
      for (int i = 0; i < 20; i++) exp_q.push_back(40 * (i + 1) + i);
      for (int i = 0; i < 32; i++) begin
         if (out_valid) got_q.push_back(int'(out_interval));
         step(i < 20, mk(i + 1, 2 * i, i), 1, 0);
         if (int'(level) > max_lvl) max_lvl = int'(level);
      end
      chk("stream_count", got_q.size(), 20);
      for (int i = 0; i < 20 && i < got_q.size(); i++) chk("stream_order", got_q[i], exp_q[i]);
      chk("stream_level_le3", int'(max_lvl <= 3), 1);
      chk("stream_overflow", int'(overflow), 0);
      // reset one cycle after a strobe discards the result in flight
      step(1, mk(5, 5, 5), 1, 0);
      step(0, '0, 1, 0);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(0, '0, 1, 0);
         chk("post_rst_valid", int'(out_valid), 0);
      end
      chk("post_rst_level", int'(level), 0);
      // random traffic, including junk on in_word while in_valid is low
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 1) == 1, 20'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
